// File: rtl/nn_mem_sequencer.sv
// nn_mem_sequencer: learn/classify address and strobe sequencer for the KMEM/WMEM dual-port memories.
// Ports: clk/rst (sync, active-high); learn/classify level requests (learn wins);
//   KMEM_*/WMEM_* port addresses, active-low write enables, tied-low OEB/CSB;
//   En/EN_IDX latency-matched weight-valid strobe and its index; busy = not IDLE.
// Optional: define NN_SEQ_DONE_EN to add the one-cycle 'done' pulse on completing a pass.
module nn_mem_sequencer #(
  parameter int ADDR_W = 5,
  parameter int N_WGT = 8,
  parameter int N_KERN = 2,
  parameter int RD_LAT = 1,
  localparam int CNT_W = $clog2(N_WGT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              learn,
  input  logic              classify,
  output logic [ADDR_W-1:0] KMEM_ADD1,
  output logic [ADDR_W-1:0] KMEM_ADD2,
  output logic [ADDR_W-1:0] WMEM_ADD1,
  output logic [ADDR_W-1:0] WMEM_ADD2,
  output logic              KMEM_WEB1,
  output logic              KMEM_WEB2,
  output logic              WMEM_WEB1,
  output logic              WMEM_WEB2,
  output logic              KMEM_OEB1,
  output logic              KMEM_OEB2,
  output logic              KMEM_CSB1,
  output logic              KMEM_CSB2,
  output logic              WMEM_OEB1,
  output logic              WMEM_OEB2,
  output logic              WMEM_CSB1,
  output logic              WMEM_CSB2,
  output logic              En,
  output logic [CNT_W-1:0]  EN_IDX,
  output logic              busy
`ifdef NN_SEQ_DONE_EN
  ,
  output logic              done
`endif
);
  typedef enum logic [1:0] {IDLE, LEARN, CLASSIFY, WAIT_REL} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  // Valid pipeline: stage RD_LAT-1 lines up with read data at WMEM port 1.
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0][CNT_W-1:0] pi_q, pi_d;
  logic push;
  always_comb begin
    state_d = state_q;
    wcnt_d = '0;
    rcnt_d = '0;
    push = 1'b0;
    case (state_q)
      IDLE: state_d = learn ? LEARN : classify ? CLASSIFY : IDLE;
      LEARN: begin
        state_d = (wcnt_q == CNT_W'(N_WGT/2-1)) ? WAIT_REL : learn ? LEARN : classify ? CLASSIFY : IDLE;
        wcnt_d = (wcnt_q != CNT_W'(N_WGT/2-1) && learn) ? wcnt_q + CNT_W'(1) : '0;
      end
      CLASSIFY: begin
        push = 1'b1;
        state_d = (rcnt_q == CNT_W'(N_WGT-1)) ? WAIT_REL : learn ? LEARN : classify ? CLASSIFY : IDLE;
        rcnt_d = (rcnt_q != CNT_W'(N_WGT-1) && !learn && classify) ? rcnt_q + CNT_W'(1) : '0;
      end
      default: state_d = (learn || classify) ? WAIT_REL : IDLE;
    endcase
    pv_d[0] = push;
    pi_d[0] = push ? rcnt_q : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      rcnt_q <= '0;
      pv_q <= '0;
      pi_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      pv_q <= pv_d;
      pi_q <= pi_d;
    end
  end
  always_comb begin
    KMEM_ADD1 = '0;
    KMEM_ADD2 = '0;
    WMEM_ADD1 = '0;
    WMEM_ADD2 = '0;
    KMEM_WEB1 = 1'b1;
    KMEM_WEB2 = 1'b1;
    WMEM_WEB1 = 1'b1;
    WMEM_WEB2 = 1'b1;
    if (state_q == LEARN) begin
      WMEM_WEB1 = 1'b0;
      WMEM_WEB2 = 1'b0;
      WMEM_ADD1 = ADDR_W'({wcnt_q, 1'b0});
      WMEM_ADD2 = ADDR_W'({wcnt_q, 1'b1});
      KMEM_WEB1 = !(wcnt_q < CNT_W'(N_KERN));
      KMEM_ADD1 = (wcnt_q < CNT_W'(N_KERN)) ? ADDR_W'(wcnt_q) : '0;
    end else if (state_q == CLASSIFY) begin
      KMEM_ADD2 = ADDR_W'(1);
      WMEM_ADD1 = ADDR_W'(rcnt_q);
    end
  end
  assign {KMEM_OEB1, KMEM_OEB2, KMEM_CSB1, KMEM_CSB2} = 4'b0;
  assign {WMEM_OEB1, WMEM_OEB2, WMEM_CSB1, WMEM_CSB2} = 4'b0;
  assign En = pv_q[RD_LAT-1];
  assign EN_IDX = pi_q[RD_LAT-1];
  assign busy = (state_q != IDLE);
`ifdef NN_SEQ_DONE_EN
  logic done_q, done_d;
  // Only a completed pass reaches WAIT_REL, so aborts never pulse.
  assign done_d = (state_d == WAIT_REL) && (state_q != WAIT_REL);
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else done_q <= done_d;
  end
  assign done = done_q;
`endif
endmodule
